alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mul_seq.sv | 49 ++++
 rtl/alu_pipe.sv | 156 +++++++++++++++
 tb/tb_alu_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag layout for the pipelined ALU.
package alu_pkg;

  localparam logic [5:0] OP_EQ    = 6'b000011;
  localparam logic [5:0] OP_LT    = 6'b000101;
  localparam logic [5:0] OP_LE    = 6'b000111;
  localparam logic [5:0] OP_LTU   = 6'b000100;
  localparam logic [5:0] OP_LEU   = 6'b000110;
  localparam logic [5:0] OP_ADD   = 6'b010000;
  localparam logic [5:0] OP_SUB   = 6'b010001;
  localparam logic [5:0] OP_AND   = 6'b101000;
  localparam logic [5:0] OP_OR    = 6'b101110;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_XNOR  = 6'b101001;
  localparam logic [5:0] OP_PASSA = 6'b101010;
  localparam logic [5:0] OP_SHL   = 6'b110000;
  localparam logic [5:0] OP_SHR   = 6'b110001;
  localparam logic [5:0] OP_SRA   = 6'b110011;
  localparam logic [5:0] OP_MUL   = 6'b011000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Packs to {v,c,n,z}, matching the flags port bit order.
  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// WIDTH clocks after start; keeps the low WIDTH bits of the product.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

  // High during the cycle whose closing edge retires the final partial product.
  assign o_done = r_busy && (r_cnt == LAST);
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshakes; MUL runs on an iterative
// multiplier under a small FSM, everything else completes in one clock.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alufn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             err
);
  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  flags_t           r_flags;
  logic             r_err;

  logic             w_out_free;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_load_op;
  logic             w_mul_load;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_sh;
  logic             w_eq;
  logic             w_lt;
  logic             w_ltu;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == IDLE) && w_out_free;
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = (alufn == OP_MUL);
  assign w_load_op  = w_accept && !w_is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && w_is_mul),
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mul_load  = 1'b0;
    case (r_state)
      IDLE: if (w_accept && w_is_mul) w_state_nxt = MUL;
      MUL:  if (w_mul_done) w_state_nxt = DONE;
      DONE: begin
        // Product is parked here until the output register can take it.
        if (w_out_free) begin
          w_mul_load  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // SUB is a + ~b + 1 so the carry-out reads as "no borrow".
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_sh   = b[SHW-1:0];
  assign w_eq   = (a == b);
  assign w_lt   = ($signed(a) < $signed(b));
  assign w_ltu  = (a < b);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (alufn)
      OP_EQ:    w_res = {{(WIDTH-1){1'b0}}, w_eq};
      OP_LT:    w_res = {{(WIDTH-1){1'b0}}, w_lt};
      OP_LE:    w_res = {{(WIDTH-1){1'b0}}, w_lt || w_eq};
      OP_LTU:   w_res = {{(WIDTH-1){1'b0}}, w_ltu};
      OP_LEU:   w_res = {{(WIDTH-1){1'b0}}, w_ltu || w_eq};
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_AND:   w_res = a & b;
      OP_OR:    w_res = a | b;
      OP_XOR:   w_res = a ^ b;
      OP_XNOR:  w_res = ~(a ^ b);
      OP_PASSA: w_res = a;
      OP_SHL:   w_res = a << w_sh;
      OP_SHR:   w_res = a >> w_sh;
      OP_SRA:   w_res = $signed(a) >>> w_sh;
      OP_MUL:   w_res = '0;
      default:  w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_flags     <= '0;
      r_err       <= 1'b0;
    end else if (w_mul_load) begin
      r_out_valid <= 1'b1;
      r_y         <= w_mul_prod;
      r_flags     <= '{v: 1'b0, c: 1'b0, n: w_mul_prod[MSB], z: ~|w_mul_prod};
      r_err       <= 1'b0;
    end else if (w_load_op) begin
      r_out_valid <= 1'b1;
      r_y         <= w_res;
      r_flags     <= '{v: w_v, c: w_c, n: w_res[MSB], z: ~|w_res};
      r_err       <= w_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign flags     = r_flags;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: expected results are queued on
// accept and compared in order as the DUT hands them out.
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] f;
    logic       e;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] alufn;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] flags;
  logic       err;

  int   tests;
  int   fails;
  bit   rnd_ready;
  exp_t q[$];

  logic [5:0] ops [17] = '{6'b000011, 6'b000101, 6'b000111, 6'b000100, 6'b000110,
                           6'b010000, 6'b010001, 6'b101000, 6'b101110, 6'b100110,
                           6'b101001, 6'b101010, 6'b110000, 6'b110001, 6'b110011,
                           6'h3F, 6'b011000};

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alufn     (alufn),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [5:0] op, input logic [7:0] aa, input logic [7:0] bb);
    int   ua, ub, sa, sb, r, sh;
    logic c, v, er;
    exp_t x;
    ua = int'(aa);
    ub = int'(bb);
    sa = int'($signed(aa));
    sb = int'($signed(bb));
    sh = ub % 8;
    r = 0; c = 1'b0; v = 1'b0; er = 1'b0;
    case (op)
      6'b000011: r = (ua == ub) ? 1 : 0;
      6'b000101: r = (sa <  sb) ? 1 : 0;
      6'b000111: r = (sa <= sb) ? 1 : 0;
      6'b000100: r = (ua <  ub) ? 1 : 0;
      6'b000110: r = (ua <= ub) ? 1 : 0;
      6'b010000: begin
        r = ua + ub;
        c = (r > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      6'b010001: begin
        r = ua + (255 - ub) + 1;
        c = (r > 255);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      6'b101000: r = ua & ub;
      6'b101110: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b101001: r = ~(ua ^ ub);
      6'b101010: r = ua;
      6'b110000: r = ua << sh;
      6'b110001: r = ua >> sh;
      6'b110011: r = sa >>> sh;
      6'b011000: r = ua * ub;
      default: begin r = 0; er = 1'b1; end
    endcase
    x.y = r[7:0];
    x.f = {v, c, x.y[7], (x.y == 8'h00)};
    x.e = er;
    return x;
  endfunction

  // Drive one op from posedge+2, push its expectation once in_ready is seen,
  // return at posedge+2 just after the accepting edge.
  task automatic send_op(input logic [5:0] op, input logic [7:0] aa, input logic [7:0] bb,
                         output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    alufn = op; a = aa; b = bb; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(op, aa, bb));
        ok = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #2;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_op_timeout op=%b in_ready=%b required 1 within 200 cycles", op, in_ready);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t       e;
    bit         p_stall;
    logic [7:0] p_y;
    logic [3:0] p_f;
    logic       p_e;
    p_stall = 1'b0; p_y = '0; p_f = '0; p_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_stall = 1'b0;
      end else begin
        if (p_stall) begin
          tests++;
          if (out_valid !== 1'b1 || y !== p_y || flags !== p_f || err !== p_e) begin
            fails++;
            $display("FAIL hold got v=%b y=%h f=%b e=%b required v=1 y=%h f=%b e=%b",
                     out_valid, y, flags, err, p_y, p_f, p_e);
          end
        end
        if (out_valid && out_ready) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result got y=%h f=%b e=%b required no output", y, flags, err);
          end else begin
            e = q.pop_front();
            if (y !== e.y || flags !== e.f || err !== e.e) begin
              fails++;
              $display("FAIL result got y=%h f=%b e=%b required y=%h f=%b e=%b",
                       y, flags, err, e.y, e.f, e.e);
            end
          end
        end
        p_stall = out_valid && !out_ready;
        p_y = y; p_f = flags; p_e = err;
      end
    end
  end

  initial begin : ready_toggler
    forever begin
      @(posedge clk); #2;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; alufn = '0; a = '0; b = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || y !== 8'h00 || flags !== 4'h0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got v=%b y=%h f=%b e=%b required 0 0 0 0", out_valid, y, flags, err);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_directed();
    int w;
    out_ready = 1'b1;
    send_op(6'b010000, 8'h7F, 8'h01, w);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || y !== 8'h80 || flags !== 4'b1010 || err !== 1'b0) begin
      fails++;
      $display("FAIL add_latency got v=%b y=%h f=%b e=%b required 1 80 1010 0", out_valid, y, flags, err);
    end
    @(posedge clk); #2;
    send_op(6'b010001, 8'h05, 8'h05, w);
    send_op(6'b000100, 8'hFF, 8'h01, w);
    send_op(6'b000101, 8'hFF, 8'h01, w);
    send_op(6'h3F,     8'h12, 8'h34, w);
    send_op(6'b110000, 8'h01, 8'h0B, w);
    send_op(6'b110011, 8'h90, 8'h02, w);
    send_op(6'b000111, 8'h80, 8'h7F, w);
    repeat (2) @(posedge clk); #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL directed_drain got %0d pending required 0", q.size());
    end
  endtask

  task automatic test_mul();
    int w, bad;
    out_ready = 1'b1;
    send_op(6'b011000, 8'h0D, 8'h0B, w);
    alufn = 6'b010000; a = 8'h01; b = 8'h01; in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      if (k == 8) in_valid = 1'b0;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mul_busy got %0d cycles with in_ready/out_valid high required 0", bad);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || y !== 8'h8F || flags !== 4'b0010 || err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mul_result got v=%b y=%h f=%b e=%b rdy=%b required 1 8f 0010 0 1",
               out_valid, y, flags, err, in_ready);
    end
    repeat (2) @(posedge clk); #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL mul_drain got %0d pending required 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    int w, tot;
    out_ready = 1'b1;
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send_op(ops[$urandom_range(0, 15)], 8'($urandom), 8'($urandom), w);
      tot += w;
    end
    tests++;
    if (tot != 0) begin
      fails++;
      $display("FAIL b2b_bubbles got %0d stall cycles required 0", tot);
    end
    @(posedge clk); #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain got %0d pending required 0", q.size());
    end
  endtask

  task automatic test_stall();
    int w;
    rnd_ready = 1'b1;
    for (int i = 0; i < 24; i++)
      send_op(ops[$urandom_range(0, 16)], 8'($urandom), 8'($urandom), w);
    for (int k = 0; k < 200 && q.size() != 0; k++) begin
      @(posedge clk); #2;
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL stall_drain got %0d pending required 0", q.size());
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset_mul();
    int w, cnt;
    out_ready = 1'b1;
    send_op(6'b010000, 8'h7F, 8'h01, w);
    send_op(6'b011000, 8'h03, 8'h05, w);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || y !== 8'h00 || flags !== 4'h0 || err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mul got v=%b y=%h f=%b e=%b rdy=%b required 0 00 0000 0 1",
               out_valid, y, flags, err, in_ready);
    end
    q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mul_ready got %b required 1", in_ready);
    end
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    tests++;
    if (cnt != 0) begin
      fails++;
      $display("FAIL reset_mul_ghost got %0d result cycles required 0", cnt);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rnd_ready = 1'b0;
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_mul();
    test_back_to_back();
    test_stall();
    test_reset_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
